// File: rtl/wb_select_stage_pkg.sv
// Shared definitions for the writeback select stage: destination encodings,
// link register number, held-entry header type and destination decode.
package wb_select_stage_pkg;

    typedef enum logic [1:0] {
        RD_RT   = 2'b00,
        RD_RD   = 2'b01,
        RD_LINK = 2'b10,
        RD_NONE = 2'b11
    } reg_dst_e;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Control part of a held entry; the DATA_W-wide data word travels beside it.
    typedef struct packed {
        logic [4:0] addr;
        logic       we;
    } wb_entry_hdr_t;

    function automatic logic [4:0] dest_addr(reg_dst_e dst, logic [4:0] rt, logic [4:0] rd);
        case (dst)
            RD_RT:   return rt;
            RD_RD:   return rd;
            RD_LINK: return LINK_REG;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/wb_select_stage_if.sv
// Writeback bus from the select stage to the register file.
interface wb_select_stage_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;

    modport master (output out_valid, wb_addr, wb_data, wb_we, input out_ready);
    modport slave  (input out_valid, wb_addr, wb_data, wb_we, output out_ready);
endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO used as the writeback skid buffer; slot0 is always the head.
module wb_skid_fifo #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [W-1:0] tail,
    output logic [1:0]   count
);
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;

    // Caller only pushes with fewer than two held and only pops when non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= wdata;
                    else               slot1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    slot0 <= wdata;
                end
                default: ;
            endcase
        end
    end

    assign head = slot0;
    assign tail = slot1;

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks the destination register and data source,
// buffers up to two entries, and optionally forwards held results (WB_SELECT_FWD_EN).
module wb_select_stage
    import wb_select_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             instr_rt,
    input  logic [4:0]             instr_rd,
    input  logic [1:0]             reg_dst,
    input  logic                   reg_write,
    input  logic [SEL_W-1:0]       data_sel,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic                   flush,
    wb_select_stage_if.master      wb,
    output logic                   sel_err,
    input  logic [4:0]             fwd_rs_addr,
    input  logic [4:0]             fwd_rt_addr,
    input  logic [DATA_W-1:0]      fwd_rs_in,
    input  logic [DATA_W-1:0]      fwd_rt_in,
    output logic [DATA_W-1:0]      fwd_rs_out,
    output logic [DATA_W-1:0]      fwd_rt_out
);
    localparam int PW = DATA_W + $bits(wb_entry_hdr_t);

    logic [DATA_W-1:0] sel_data;
    logic              sel_ok;
    wb_entry_hdr_t     new_hdr;
    logic              push;
    logic              pop;
    logic              live;
    logic [1:0]        count;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] tail_data;
    wb_entry_hdr_t     head_hdr;
    wb_entry_hdr_t     tail_hdr;

    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (data_sel == SEL_W'(i)) begin
                sel_data = src_data[i*DATA_W +: DATA_W];
                sel_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        new_hdr.addr = dest_addr(reg_dst_e'(reg_dst), instr_rt, instr_rd);
        new_hdr.we   = reg_write && (reg_dst != RD_NONE) && (new_hdr.addr != 5'd0) && sel_ok;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready depends only on held state and flush, never on out_ready.
    assign in_ready = live && (count != 2'd2) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = wb.out_valid && wb.out_ready;

    // live holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push && !sel_ok) sel_err <= 1'b1;
        end
    end

    wb_skid_fifo #(.W(PW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({sel_data, new_hdr}),
        .head  (head),
        .tail  (tail),
        .count (count)
    );

    assign {head_data, head_hdr} = head;
    assign {tail_data, tail_hdr} = tail;

    assign wb.out_valid = (count != 2'd0);
    assign wb.wb_addr   = wb.out_valid ? head_hdr.addr : 5'd0;
    assign wb.wb_data   = wb.out_valid ? head_data : '0;
    assign wb.wb_we     = wb.out_valid && head_hdr.we;

`ifdef WB_SELECT_FWD_EN
    // Tail is younger than head, so a tail match overrides a head match.
    always_comb begin
        fwd_rs_out = fwd_rs_in;
        fwd_rt_out = fwd_rt_in;
        if (count != 2'd0 && head_hdr.we && head_hdr.addr == fwd_rs_addr) fwd_rs_out = head_data;
        if (count != 2'd0 && head_hdr.we && head_hdr.addr == fwd_rt_addr) fwd_rt_out = head_data;
        if (count == 2'd2 && tail_hdr.we && tail_hdr.addr == fwd_rs_addr) fwd_rs_out = tail_data;
        if (count == 2'd2 && tail_hdr.we && tail_hdr.addr == fwd_rt_addr) fwd_rt_out = tail_data;
    end
`else
    assign fwd_rs_out = fwd_rs_in;
    assign fwd_rt_out = fwd_rt_in;

    logic unused_fwd;
    assign unused_fwd = ^{fwd_rs_addr, fwd_rt_addr, tail_data, tail_hdr};
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage (NSRC=3): vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_select_stage;
    localparam int DW   = 32;
    localparam int NSRC = 3;
    localparam int EW   = 5 + DW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    instr_rt = '0;
    logic [4:0]    instr_rd = '0;
    logic [1:0]    reg_dst = '0;
    logic          reg_write = 1'b0;
    logic [1:0]    data_sel = '0;
    logic [DW-1:0] src [NSRC];
    logic [NSRC*DW-1:0] src_data;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          sel_err;
    logic [4:0]    fwd_rs_addr = '0;
    logic [4:0]    fwd_rt_addr = '0;
    logic [DW-1:0] fwd_rs_in = '0;
    logic [DW-1:0] fwd_rt_in = '0;
    logic [DW-1:0] fwd_rs_out;
    logic [DW-1:0] fwd_rt_out;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];
    bit m_err;
    bit m_live;

    wb_select_stage_if #(.DATA_W(DW)) wb_bus ();
    assign wb_bus.out_ready = out_ready;
    assign src_data = {src[2], src[1], src[0]};

    wb_select_stage #(.DATA_W(DW), .NSRC(NSRC), .SEL_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_rt    (instr_rt),
        .instr_rd    (instr_rd),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .data_sel    (data_sel),
        .src_data    (src_data),
        .flush       (flush),
        .wb          (wb_bus),
        .sel_err     (sel_err),
        .fwd_rs_addr (fwd_rs_addr),
        .fwd_rt_addr (fwd_rt_addr),
        .fwd_rs_in   (fwd_rs_in),
        .fwd_rt_in   (fwd_rt_in),
        .fwd_rs_out  (fwd_rs_out),
        .fwd_rt_out  (fwd_rt_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference model
    function automatic logic [EW-1:0] model_entry();
        logic [4:0]    a;
        logic [DW-1:0] d;
        bit            legal;
        case (reg_dst)
            2'd0:    a = instr_rt;
            2'd1:    a = instr_rd;
            2'd2:    a = 5'd31;
            default: a = 5'd0;
        endcase
        legal = (int'(data_sel) < NSRC);
        d = legal ? src[data_sel] : '0;
        return {a, d, (reg_write && reg_dst != 2'd3 && a != 5'd0 && legal)};
    endfunction

    function automatic logic [DW-1:0] fwd_model(logic [4:0] addr, logic [DW-1:0] rf);
        logic [DW-1:0] r = rf;
`ifdef WB_SELECT_FWD_EN
        foreach (exp_q[i]) begin
            if (exp_q[i][0] && exp_q[i][EW-1 -: 5] == addr) r = exp_q[i][DW:1];
        end
`endif
        return r;
    endfunction

    // one cycle: inputs already driven after a falling edge
    task automatic step(string tag);
        bit            ev;
        bit            exp_ready;
        bit            push;
        logic [EW-1:0] h;
        #1;
        ev = (exp_q.size() > 0);
        h = ev ? exp_q[0] : '0;
        exp_ready = m_live && (exp_q.size() < 2) && !flush;
        chk({tag, ".out_valid"}, wb_bus.out_valid, ev);
        chk({tag, ".wb_addr"}, wb_bus.wb_addr, h[EW-1 -: 5]);
        chk({tag, ".wb_data"}, wb_bus.wb_data, h[DW:1]);
        chk({tag, ".wb_we"}, wb_bus.wb_we, h[0]);
        chk({tag, ".in_ready"}, in_ready, exp_ready);
        chk({tag, ".sel_err"}, sel_err, m_err);
        chk({tag, ".fwd_rs"}, fwd_rs_out, fwd_model(fwd_rs_addr, fwd_rs_in));
        chk({tag, ".fwd_rt"}, fwd_rt_out, fwd_model(fwd_rt_addr, fwd_rt_in));
        push = in_valid && exp_ready;
        if (flush) exp_q.delete();
        else begin
            if (ev && out_ready) void'(exp_q.pop_front());
            if (push) exp_q.push_back(model_entry());
        end
        if (push && int'(data_sel) >= NSRC) m_err = 1'b1;
        m_live = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver tasks
    task automatic drive(bit v, logic [1:0] dst, logic [4:0] rt, logic [4:0] rd,
                         bit rw, logic [1:0] sel);
        in_valid = v; reg_dst = dst; instr_rt = rt; instr_rd = rd;
        reg_write = rw; data_sel = sel;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", wb_bus.out_valid, 1'b0);
        chk("rst.wb_we", wb_bus.wb_we, 1'b0);
        chk("rst.wb_addr", wb_bus.wb_addr, 5'd0);
        chk("rst.wb_data", wb_bus.wb_data, 32'd0);
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.sel_err", sel_err, 1'b0);
        exp_q.delete();
        m_err = 1'b0;
        m_live = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release");
        #1 chk("rst.in_ready_after", in_ready, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  dst;
        logic [4:0]  rt, rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] s0, s1, s2;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_we;
    } vec_t;
    vec_t vecs[6];

    initial begin
        foreach (src[i]) src[i] = '0;
        vecs[0] = '{2'd1, 5'd3,  5'd8, 1'b1, 2'd1, 32'h0, 32'h1234, 32'h0, 5'd8, 32'h1234, 1'b1};
        vecs[1] = '{2'd2, 5'd4,  5'd9, 1'b1, 2'd2, 32'h1, 32'h2, 32'h00400008, 5'd31, 32'h00400008, 1'b1};
        vecs[2] = '{2'd0, 5'd0,  5'd7, 1'b1, 2'd0, 32'hdead, 32'h0, 32'h0, 5'd0, 32'hdead, 1'b0};
        vecs[3] = '{2'd0, 5'd17, 5'd7, 1'b0, 2'd0, 32'hcafe, 32'h0, 32'h0, 5'd17, 32'hcafe, 1'b0};
        vecs[4] = '{2'd3, 5'd2,  5'd9, 1'b1, 2'd1, 32'h0, 32'hbeef, 32'h0, 5'd0, 32'hbeef, 1'b0};
        vecs[5] = '{2'd1, 5'd2,  5'd2, 1'b1, 2'd3, 32'h5, 32'h6, 32'h7, 5'd2, 32'h0, 1'b0};

        m_err = 1'b0;
        m_live = 1'b0;
        @(negedge clk);
        do_reset();

        // vector table: single push into an empty buffer, then pop
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            src[0] = vecs[i].s0; src[1] = vecs[i].s1; src[2] = vecs[i].s2;
            drive(1'b1, vecs[i].dst, vecs[i].rt, vecs[i].rd, vecs[i].rw, vecs[i].sel);
            step("vec_push");
            in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d.out_valid", i), wb_bus.out_valid, 1'b1);
            chk($sformatf("vec%0d.wb_addr", i), wb_bus.wb_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d.wb_data", i), wb_bus.wb_data, vecs[i].e_data);
            chk($sformatf("vec%0d.wb_we", i), wb_bus.wb_we, vecs[i].e_we);
            step("vec_pop");
        end
        chk("sel_err.set", sel_err, 1'b1);

        // three pushes against a stalled consumer: two accepted, order kept
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            src[0] = 32'h100 + k;
            drive(1'b1, 2'd1, 5'd1, 5'(10 + k), 1'b1, 2'd0);
            step("bp_push");
        end
        in_valid = 1'b0;
        #1 chk("bp.in_ready_full", in_ready, 1'b0);
        for (int k = 0; k < 4; k++) step("bp_hold");
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("bp.drain%0d_data", k), wb_bus.wb_data, 32'h100 + k);
            chk($sformatf("bp.drain%0d_addr", k), wb_bus.wb_addr, 5'(10 + k));
            step("bp_drain");
        end
        #1 chk("bp.empty", wb_bus.out_valid, 1'b0);
        chk("sel_err.sticky", sel_err, 1'b1);

        // flush with two held and a push offered
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd1, 5'd1, 5'(20 + k), 1'b1, 2'd0);
            step("fl_fill");
        end
        flush = 1'b1;
        drive(1'b1, 2'd1, 5'd1, 5'd22, 1'b1, 2'd0);
        step("fl_flush");
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush.out_valid", wb_bus.out_valid, 1'b0);
        step("fl_after");

        // forwarding from two held entries for the same register
        src[0] = 32'hA;
        drive(1'b1, 2'd1, 5'd1, 5'd5, 1'b1, 2'd0);
        step("fw_a");
        src[0] = 32'hB;
        step("fw_b");
        in_valid = 1'b0;
        fwd_rs_addr = 5'd5; fwd_rs_in = 32'h5555;
        fwd_rt_addr = 5'd6; fwd_rt_in = 32'h6666;
        #1;
`ifdef WB_SELECT_FWD_EN
        chk("fwd.rs_tail", fwd_rs_out, 32'hB);
`else
        chk("fwd.rs_pass", fwd_rs_out, 32'h5555);
`endif
        chk("fwd.rt_miss", fwd_rt_out, 32'h6666);
        step("fw_hold");

        // reset in the middle of traffic drops everything
        do_reset();
        #1 chk("midrst.out_valid", wb_bus.out_valid, 1'b0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 4);
            reg_dst   = 2'($urandom_range(0, 3));
            instr_rt  = 5'($urandom_range(0, 7));
            instr_rd  = 5'($urandom_range(0, 7));
            reg_write = ($urandom_range(0, 3) != 0);
            data_sel  = 2'($urandom_range(0, 3));
            foreach (src[i]) src[i] = $urandom;
            fwd_rs_addr = 5'($urandom_range(0, 7));
            fwd_rt_addr = 5'($urandom_range(0, 7));
            fwd_rs_in = $urandom;
            fwd_rt_in = $urandom;
            if (n == 700) do_reset();
            else step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
